// File: rtl/ahb_mst_in_stage_pkg.sv
// Shared encodings for the per-master AHB-Lite input stage: HTRANS/HRESP
// values and the stage FSM state type.
package ahb_mst_in_stage_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DPH  = 2'd2
  } stage_state_e;

  // Width of the packed address/control bundle kept in the holding register.
  function automatic int ctrl_width(input int addr_width);
    return addr_width + 2 + 1 + 3 + 3 + 4;
  endfunction

endpackage

// File: rtl/ahb_mst_in_stage_if.sv
// Bus bundle around one master input stage: master-side AHB signals,
// the request/control lines toward the matrix, and the data-phase return.
interface ahb_mst_in_stage_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int PRI_WIDTH  = 1
) ();
  // Handshake: an address phase is offered while m_req=1 and is taken in the
  // cycle m_ack=1; the stage holds it stable (m_* frozen) until that cycle.
  logic                  hsel_s;
  logic [ADDR_WIDTH-1:0] haddr_s;
  logic [1:0]            htrans_s;
  logic                  hwrite_s;
  logic [2:0]            hsize_s;
  logic [2:0]            hburst_s;
  logic [3:0]            hprot_s;
  logic                  hready_s;
  logic                  hreadyout_s;
  logic                  hresp_s;
  logic                  m_req;
  logic [PRI_WIDTH-1:0]  m_pri;
  logic                  m_hold;
  logic [ADDR_WIDTH-1:0] m_haddr;
  logic [1:0]            m_htrans;
  logic                  m_hwrite;
  logic [2:0]            m_hsize;
  logic [2:0]            m_hburst;
  logic [3:0]            m_hprot;
  logic                  m_ack;
  logic                  d_hready;
  logic                  d_hresp;

  modport master (
    output hsel_s, haddr_s, htrans_s, hwrite_s, hsize_s, hburst_s, hprot_s,
    output hready_s, m_ack, d_hready, d_hresp,
    input  hreadyout_s, hresp_s, m_req, m_pri, m_hold,
    input  m_haddr, m_htrans, m_hwrite, m_hsize, m_hburst, m_hprot
  );

  modport slave (
    input  hsel_s, haddr_s, htrans_s, hwrite_s, hsize_s, hburst_s, hprot_s,
    input  hready_s, m_ack, d_hready, d_hresp,
    output hreadyout_s, hresp_s, m_req, m_pri, m_hold,
    output m_haddr, m_htrans, m_hwrite, m_hsize, m_hburst, m_hprot
  );
endinterface

// File: rtl/ahb_mst_in_stage_addr_hold_reg.sv
// Enable-loaded holding register for a stalled address phase, plus the
// live/held mux feeding the matrix.
module ahb_addr_hold_reg #(
  parameter int W = 45
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         sel_held_i,
  input  logic [W-1:0] live_i,
  output logic [W-1:0] out_o,
  output logic [W-1:0] held_o
);

  logic [W-1:0] hold_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      hold_q <= '0;
    else if (load_i) hold_q <= live_i;
  end

  assign out_o  = sel_held_i ? hold_q : live_i;
  assign held_o = hold_q;

endmodule

// File: rtl/ahb_mst_in_stage.sv
// Per-master AHB-Lite input stage: forwards or holds the address phase,
// then returns the slave port's ready/response during the data phase.
module ahb_mst_in_stage
  import ahb_mst_in_stage_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int PRI_WIDTH  = 1,
  parameter int MST_PRI    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ahb_mst_in_stage_if.slave     bus,
  output stage_state_e          state_o,
  output logic [ADDR_WIDTH-1:0] held_haddr_o
);

  localparam int CW = ctrl_width(ADDR_WIDTH);

  stage_state_e state_q;
  logic         live_vld;
  logic         open_slot;
  logic         cap_en;
  logic [CW-1:0] live_ctrl;
  logic [CW-1:0] mux_ctrl;
  logic [CW-1:0] held_ctrl;

  // rst_n gates the request so the arbiter never sees m_req during reset.
  assign live_vld  = bus.hsel_s & bus.htrans_s[1] & bus.hready_s & rst_n;
  assign open_slot = (state_q == ST_IDLE) | ((state_q == ST_DPH) & bus.d_hready);
  assign cap_en    = open_slot & live_vld & ~bus.m_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_WAIT: if (bus.m_ack) state_q <= ST_DPH;
        default: begin
          if (open_slot) begin
            if (live_vld && bus.m_ack) state_q <= ST_DPH;
            else if (live_vld)         state_q <= ST_WAIT;
            else                       state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign live_ctrl = {bus.haddr_s, bus.htrans_s, bus.hwrite_s,
                      bus.hsize_s, bus.hburst_s, bus.hprot_s};

  ahb_addr_hold_reg #(.W(CW)) u_hold (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cap_en),
    .sel_held_i (state_q == ST_WAIT),
    .live_i     (live_ctrl),
    .out_o      (mux_ctrl),
    .held_o     (held_ctrl)
  );

  assign {bus.m_haddr, bus.m_htrans, bus.m_hwrite,
          bus.m_hsize, bus.m_hburst, bus.m_hprot} = mux_ctrl;

  assign bus.m_req  = (state_q == ST_WAIT) | live_vld;
  assign bus.m_pri  = PRI_WIDTH'(MST_PRI);
  // SEQ and BUSY both have htrans[0] set: the burst is still running.
  assign bus.m_hold = bus.hsel_s & bus.htrans_s[0];

  always_comb begin
    bus.hreadyout_s = 1'b1;
    bus.hresp_s     = HRESP_OKAY;
    case (state_q)
      ST_WAIT: bus.hreadyout_s = 1'b0;
      ST_DPH: begin
        bus.hreadyout_s = bus.d_hready;
        bus.hresp_s     = bus.d_hresp;
      end
      default: ;
    endcase
  end

  assign state_o      = state_q;
  assign held_haddr_o = held_ctrl[CW-1 -: ADDR_WIDTH];

endmodule

// File: tb/tb_ahb_mst_in_stage.sv
// Directed bench for ahb_mst_in_stage: single transfers, stalls, bursts,
// error response, back-to-back capture and reset during a stall.
module tb_ahb_mst_in_stage;
  import ahb_mst_in_stage_pkg::*;

  logic         clk;
  logic         rst_n;
  stage_state_e state;
  logic [31:0]  held_haddr;
  logic [31:0]  exp_q[$];
  int           total;
  int           bad;
  int           n_acc;

  ahb_mst_in_stage_if #(.ADDR_WIDTH(32), .PRI_WIDTH(1)) bus ();

  ahb_mst_in_stage #(.ADDR_WIDTH(32), .PRI_WIDTH(1), .MST_PRI(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .state_o      (state),
    .held_haddr_o (held_haddr)
  );

  // Single-master layer: the layer ready is the ready returned by the stage.
  assign bus.hready_s = bus.hreadyout_s;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic bus_idle();
    bus.hsel_s   = 1'b0;
    bus.haddr_s  = '0;
    bus.htrans_s = HTRANS_IDLE;
    bus.hwrite_s = 1'b0;
    bus.hsize_s  = 3'd2;
    bus.hburst_s = 3'd0;
    bus.hprot_s  = 4'd3;
  endtask

  task automatic drive_addr(input logic [31:0] a, input logic [1:0] tr,
                            input logic wr, input logic [2:0] burst);
    bus.hsel_s   = 1'b1;
    bus.haddr_s  = a;
    bus.htrans_s = tr;
    bus.hwrite_s = wr;
    bus.hsize_s  = 3'd2;
    bus.hburst_s = burst;
    bus.hprot_s  = 4'd3;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic sb_accept(input string tag);
    if (bus.m_req && bus.m_ack) begin
      n_acc++;
      if (exp_q.size() == 0) chk({tag, "_extra"}, 64'(bus.m_haddr), 64'hDEAD);
      else                   chk({tag, "_addr"}, 64'(bus.m_haddr), 64'(exp_q.pop_front()));
    end
  endtask

  // ---------------- stimulus ----------------
  logic [1:0]  b_tr  [5];
  logic [31:0] b_addr[5];
  logic        b_req [5];
  logic        b_hold[5];

  initial begin
    total = 0;
    bad   = 0;
    n_acc = 0;
    rst_n = 1'b0;
    bus_idle();
    bus.m_ack    = 1'b0;
    bus.d_hready = 1'b1;
    bus.d_hresp  = 1'b0;

    // Reset: a live NONSEQ must not raise m_req while rst_n is low.
    drive_addr(32'h0000_0AAA, HTRANS_NONSEQ, 1'b0, 3'd0);
    repeat (3) step();
    chk("rst_state", 64'(state), 64'(ST_IDLE));
    chk("rst_rdy", 64'(bus.hreadyout_s), 64'd1);
    chk("rst_resp", 64'(bus.hresp_s), 64'd0);
    chk("rst_req", 64'(bus.m_req), 64'd0);
    chk("rst_pri", 64'(bus.m_pri), 64'd1);
    bus_idle();
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 1: NONSEQ read acked in the same cycle, then one data-phase wait state.
    drive_addr(32'h1000, HTRANS_NONSEQ, 1'b0, 3'd0);
    bus.m_ack = 1'b1;
    settle();
    chk("t1_req", 64'(bus.m_req), 64'd1);
    chk("t1_addr", 64'(bus.m_haddr), 64'h1000);
    chk("t1_rdy", 64'(bus.hreadyout_s), 64'd1);
    step();
    bus_idle();
    bus.m_ack    = 1'b0;
    bus.d_hready = 1'b0;
    settle();
    chk("t1_dph", 64'(state), 64'(ST_DPH));
    chk("t1_ws", 64'(bus.hreadyout_s), 64'd0);
    step();
    bus.d_hready = 1'b1;
    settle();
    chk("t1_dph2", 64'(state), 64'(ST_DPH));
    chk("t1_rdy2", 64'(bus.hreadyout_s), 64'd1);
    step();
    chk("t1_idle", 64'(state), 64'(ST_IDLE));

    // 2: NONSEQ write stalled for three cycles, master address changes meanwhile.
    drive_addr(32'h2000, HTRANS_NONSEQ, 1'b1, 3'd0);
    settle();
    chk("t2_req", 64'(bus.m_req), 64'd1);
    step();
    bus.haddr_s  = 32'hFFFF;
    bus.hwrite_s = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.m_ack = (i == 2);
      settle();
      chk("t2_wait", 64'(state), 64'(ST_WAIT));
      chk("t2_rdy", 64'(bus.hreadyout_s), 64'd0);
      chk("t2_addr", 64'(bus.m_haddr), 64'h2000);
      chk("t2_wr", 64'(bus.m_hwrite), 64'd1);
      chk("t2_req_w", 64'(bus.m_req), 64'd1);
      step();
    end
    bus_idle();
    bus.m_ack = 1'b0;
    settle();
    chk("t2_dph", 64'(state), 64'(ST_DPH));
    chk("t2_rdy_d", 64'(bus.hreadyout_s), 64'd1);
    step();
    chk("t2_idle", 64'(state), 64'(ST_IDLE));

    // 3: INCR4 burst with a BUSY beat between the second and third beat.
    b_tr   = '{HTRANS_NONSEQ, HTRANS_SEQ, HTRANS_BUSY, HTRANS_SEQ, HTRANS_SEQ};
    b_addr = '{32'h3000, 32'h3004, 32'h3008, 32'h3008, 32'h300C};
    b_req  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    b_hold = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_q  = '{32'h3000, 32'h3004, 32'h3008, 32'h300C};
    n_acc  = 0;
    bus.m_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_addr(b_addr[i], b_tr[i], 1'b0, 3'd3);
      settle();
      chk("t3_req", 64'(bus.m_req), 64'(b_req[i]));
      chk("t3_hold", 64'(bus.m_hold), 64'(b_hold[i]));
      sb_accept("t3");
      step();
    end
    bus_idle();
    bus.m_ack = 1'b0;
    chk("t3_count", 64'(n_acc), 64'd4);
    chk("t3_left", 64'(exp_q.size()), 64'd0);
    step();
    chk("t3_idle", 64'(state), 64'(ST_IDLE));

    // 4: two-cycle ERROR response; master cancels to IDLE in the second cycle.
    drive_addr(32'h4000, HTRANS_NONSEQ, 1'b0, 3'd0);
    bus.m_ack = 1'b1;
    step();
    bus.m_ack    = 1'b0;
    bus.d_hready = 1'b0;
    bus.d_hresp  = 1'b1;
    settle();
    chk("t4_resp1", 64'(bus.hresp_s), 64'd1);
    chk("t4_rdy1", 64'(bus.hreadyout_s), 64'd0);
    step();
    bus.htrans_s = HTRANS_IDLE;
    bus.d_hready = 1'b1;
    settle();
    chk("t4_resp2", 64'(bus.hresp_s), 64'd1);
    chk("t4_rdy2", 64'(bus.hreadyout_s), 64'd1);
    chk("t4_req2", 64'(bus.m_req), 64'd0);
    step();
    bus.d_hresp = 1'b0;
    settle();
    chk("t4_idle", 64'(state), 64'(ST_IDLE));
    chk("t4_resp3", 64'(bus.hresp_s), 64'd0);
    bus_idle();

    // 5: back-to-back; the second address is captured as the first data phase ends.
    exp_q = '{32'h5000, 32'h5004};
    n_acc = 0;
    drive_addr(32'h5000, HTRANS_NONSEQ, 1'b1, 3'd0);
    bus.m_ack = 1'b1;
    settle();
    sb_accept("t5");
    step();
    drive_addr(32'h5004, HTRANS_NONSEQ, 1'b0, 3'd0);
    bus.m_ack = 1'b0;
    settle();
    chk("t5_req", 64'(bus.m_req), 64'd1);
    chk("t5_rdy", 64'(bus.hreadyout_s), 64'd1);
    sb_accept("t5");
    step();
    bus.m_ack = 1'b1;
    settle();
    chk("t5_wait", 64'(state), 64'(ST_WAIT));
    chk("t5_held", 64'(held_haddr), 64'h5004);
    sb_accept("t5");
    step();
    bus_idle();
    bus.m_ack = 1'b0;
    settle();
    chk("t5_dph", 64'(state), 64'(ST_DPH));
    chk("t5_count", 64'(n_acc), 64'd2);
    chk("t5_left", 64'(exp_q.size()), 64'd0);
    step();
    chk("t5_idle", 64'(state), 64'(ST_IDLE));

    // 6: reset asserted during WAIT drops the transfer immediately.
    drive_addr(32'h6000, HTRANS_NONSEQ, 1'b0, 3'd0);
    step();
    chk("t6_wait", 64'(state), 64'(ST_WAIT));
    chk("t6_held", 64'(held_haddr), 64'h6000);
    rst_n = 1'b0;
    settle();
    chk("t6_rdy", 64'(bus.hreadyout_s), 64'd1);
    chk("t6_req", 64'(bus.m_req), 64'd0);
    chk("t6_state", 64'(state), 64'(ST_IDLE));
    step();
    bus_idle();
    rst_n = 1'b1;
    step();
    chk("t6_idle", 64'(state), 64'(ST_IDLE));
    chk("t6_clr", 64'(held_haddr), 64'h0);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
